// File: rtl/stopwatch_pkg.sv
// Shared encodings for the BCD stopwatch/countdown timer: FSM states, digit
// positions on the 32-bit time bus, digit moduli and count direction.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned NUM_DIG = 8;

    localparam int unsigned DIG_C0 = 0;
    localparam int unsigned DIG_C1 = 1;
    localparam int unsigned DIG_S0 = 2;
    localparam int unsigned DIG_S1 = 3;
    localparam int unsigned DIG_M0 = 4;
    localparam int unsigned DIG_M1 = 5;
    localparam int unsigned DIG_H0 = 6;
    localparam int unsigned DIG_H1 = 7;

    localparam int unsigned MOD_DEC = 10;
    localparam int unsigned MOD_SEX = 6;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Clamp an out-of-range BCD digit to the largest value its modulus allows.
    function automatic logic [DIG_W-1:0] sat_digit(input logic [DIG_W-1:0] d,
                                                   input int unsigned    modulus);
        sat_digit = (d > DIG_W'(modulus - 1)) ? DIG_W'(modulus - 1) : d;
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit with parametric modulus that counts up or down on enable and
// reports a carry (up) or borrow (down) combinationally for the next digit.
module bcd_updown_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MOD = MOD_DEC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [DIG_W-1:0] ld_val,
    output logic [DIG_W-1:0] digit,
    output logic             carry_c
);

    localparam logic [DIG_W-1:0] MAX_VAL = DIG_W'(MOD - 1);

    logic [DIG_W-1:0] digit_q;
    logic [DIG_W-1:0] digit_d;

    assign carry_c = en && ((dir == MODE_DOWN) ? (digit_q == '0) : (digit_q == MAX_VAL));

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = ld_val;
        end else if (en) begin
            if (dir == MODE_DOWN) begin
                digit_d = (digit_q == '0) ? MAX_VAL : digit_q - DIG_W'(1);
            end else begin
                digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + DIG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/stopwatch_timer.sv
// hh:mm:ss.cc BCD stopwatch / countdown timer with run/pause control, preset
// load with saturation, lap capture and expiry/overflow pulses.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned TICK_W   = 19,
    parameter int unsigned HR_LIMIT = 99
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_mode,
    input  logic        i_load,
    input  logic [31:0] i_preset,
    input  logic        i_lap,
    output logic [31:0] o_time,
    output logic [31:0] o_lap,
    output logic        o_lap_valid,
    output logic        o_running,
    output logic        o_done,
    output logic        o_overflow
);

    localparam int unsigned       TIME_W    = NUM_DIG * DIG_W;
    localparam logic [DIG_W-1:0]  HR_H1     = DIG_W'(HR_LIMIT / 10);
    localparam logic [DIG_W-1:0]  HR_H0     = DIG_W'(HR_LIMIT % 10);
    localparam logic [DIG_W-1:0]  DEC_MAX   = DIG_W'(MOD_DEC - 1);
    localparam logic [DIG_W-1:0]  SEX_MAX   = DIG_W'(MOD_SEX - 1);
    localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] TIME_MAX  = {HR_H1, HR_H0, SEX_MAX, DEC_MAX,
                                               SEX_MAX, DEC_MAX, DEC_MAX, DEC_MAX};
    localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [TIME_W-1:0]  lap_q, lap_d;
    logic               lap_valid_q, lap_valid_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [DIG_W-1:0]   h1_q, h1_d;
    logic [DIG_W-1:0]   h0_q, h0_d;

    logic [TIME_W-1:0]  cur_time;
    logic [TIME_W-1:0]  sat_preset;
    logic [DIG_W-1:0]   h1_sat, h0_sat;
    logic               tick_c;
    logic               ld_c;
    logic [TIME_W-1:0]  ld_val_c;
    logic [DIG_H0:0]    chain_c;

    // Preset saturation: each digit to its own maximum, then hours to HR_LIMIT.
    always_comb begin
        sat_preset = '0;
        sat_preset[DIG_C0*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_C0*DIG_W +: DIG_W], MOD_DEC);
        sat_preset[DIG_C1*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_C1*DIG_W +: DIG_W], MOD_DEC);
        sat_preset[DIG_S0*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_S0*DIG_W +: DIG_W], MOD_DEC);
        sat_preset[DIG_S1*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_S1*DIG_W +: DIG_W], MOD_SEX);
        sat_preset[DIG_M0*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_M0*DIG_W +: DIG_W], MOD_DEC);
        sat_preset[DIG_M1*DIG_W +: DIG_W] = sat_digit(i_preset[DIG_M1*DIG_W +: DIG_W], MOD_SEX);
        h1_sat = sat_digit(i_preset[DIG_H1*DIG_W +: DIG_W], MOD_DEC);
        h0_sat = sat_digit(i_preset[DIG_H0*DIG_W +: DIG_W], MOD_DEC);
        if ((h1_sat > HR_H1) || ((h1_sat == HR_H1) && (h0_sat > HR_H0))) begin
            h1_sat = HR_H1;
            h0_sat = HR_H0;
        end
        sat_preset[DIG_H1*DIG_W +: DIG_W] = h1_sat;
        sat_preset[DIG_H0*DIG_W +: DIG_W] = h0_sat;
    end

    assign tick_c = (state_q == ST_RUN) && !i_clear && (presc_q == PRESC_MAX);

    // Centisecond through minute digits; the ripple chain ends in the hour enable.
    assign chain_c[0] = tick_c;
    for (genvar gi = 0; gi < int'(DIG_H0); gi++) begin : g_digit
        localparam int unsigned DMOD = ((gi == int'(DIG_S1)) || (gi == int'(DIG_M1))) ? MOD_SEX : MOD_DEC;
        bcd_updown_digit #(
            .MOD(DMOD)
        ) u_digit (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .en      (chain_c[gi]),
            .dir     (mode_q),
            .load    (ld_c),
            .ld_val  (ld_val_c[gi*DIG_W +: DIG_W]),
            .digit   (cur_time[gi*DIG_W +: DIG_W]),
            .carry_c (chain_c[gi+1])
        );
    end

    assign cur_time[DIG_H0*DIG_W +: DIG_W] = h0_q;
    assign cur_time[DIG_H1*DIG_W +: DIG_W] = h1_q;

    // Two-digit hour counter that wraps at HR_LIMIT rather than 99.
    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        if (ld_c) begin
            h1_d = ld_val_c[DIG_H1*DIG_W +: DIG_W];
            h0_d = ld_val_c[DIG_H0*DIG_W +: DIG_W];
        end else if (chain_c[DIG_H0]) begin
            if (mode_q == MODE_DOWN) begin
                if (h0_q != '0) begin
                    h0_d = h0_q - DIG_W'(1);
                end else if (h1_q != '0) begin
                    h0_d = DEC_MAX;
                    h1_d = h1_q - DIG_W'(1);
                end else begin
                    h1_d = HR_H1;
                    h0_d = HR_H0;
                end
            end else begin
                if ((h1_q == HR_H1) && (h0_q == HR_H0)) begin
                    h1_d = '0;
                    h0_d = '0;
                end else if (h0_q == DEC_MAX) begin
                    h0_d = '0;
                    h1_d = h1_q + DIG_W'(1);
                end else begin
                    h0_d = h0_q + DIG_W'(1);
                end
            end
        end
    end

    // Control FSM, prescaler and lap capture.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        done_d      = 1'b0;
        overflow_d  = 1'b0;
        ld_c        = 1'b0;
        ld_val_c    = '0;

        if ((state_q == ST_IDLE) && !i_clear) begin
            mode_d = i_mode;
        end

        if (!i_clear && i_lap && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
            lap_d       = cur_time;
            lap_valid_d = 1'b1;
        end

        if (i_clear) begin
            ld_c        = 1'b1;
            presc_d     = '0;
            lap_d       = '0;
            lap_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else if (i_load && (state_q != ST_RUN)) begin
            ld_c     = 1'b1;
            ld_val_c = sat_preset;
            presc_d  = '0;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start && !((i_mode == MODE_DOWN) && (cur_time == '0))) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    presc_d = tick_c ? '0 : presc_q + TICK_W'(1);
                    if (i_stop) begin
                        state_d = ST_PAUSE;
                    end
                    // Expiry overrides a same-cycle pause request.
                    if (tick_c) begin
                        if (mode_q == MODE_UP) begin
                            overflow_d = (cur_time == TIME_MAX);
                        end else if (cur_time == TIME_ONE) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_start && !i_stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_UP;
            presc_q     <= '0;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            h1_q        <= '0;
            h0_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
        end
    end

    assign o_time      = cur_time;
    assign o_lap       = lap_q;
    assign o_lap_valid = lap_valid_q;
    assign o_running   = running_q;
    assign o_done      = done_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: directed scenarios plus random control traffic,
// every cycle compared against a centisecond-count reference model.
module tb_stopwatch_timer;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;
    localparam int HR_LIMIT = 23;
    localparam int DAY_CS   = (HR_LIMIT + 1) * 360000;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic        stop;
    logic        mode;
    logic        load;
    logic [31:0] preset;
    logic        lap;
    logic [31:0] o_time;
    logic [31:0] o_lap;
    logic        o_lap_valid;
    logic        o_running;
    logic        o_done;
    logic        o_overflow;

    always #5 clk = ~clk;

    stopwatch_timer #(
        .TICK_DIV(TICK_DIV),
        .TICK_W  (TICK_W),
        .HR_LIMIT(HR_LIMIT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_start    (start),
        .i_stop     (stop),
        .i_mode     (mode),
        .i_load     (load),
        .i_preset   (preset),
        .i_lap      (lap),
        .o_time     (o_time),
        .o_lap      (o_lap),
        .o_lap_valid(o_lap_valid),
        .o_running  (o_running),
        .o_done     (o_done),
        .o_overflow (o_overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: time as total centiseconds.
    int m_state = M_IDLE;
    int m_t     = 0;
    int m_lap   = 0;
    int m_runs  = 0;
    bit m_lapv  = 1'b0;
    bit m_down  = 1'b0;
    bit m_done  = 1'b0;
    bit m_ovf   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int nib(input logic [31:0] v, input int idx);
        return int'(v[idx*4 +: 4]);
    endfunction

    function automatic int preset_to_cs(input logic [31:0] p);
        int c, s, m, h;
        c = clampi(nib(p, 1), 9) * 10 + clampi(nib(p, 0), 9);
        s = clampi(nib(p, 3), 5) * 10 + clampi(nib(p, 2), 9);
        m = clampi(nib(p, 5), 5) * 10 + clampi(nib(p, 4), 9);
        h = clampi(clampi(nib(p, 7), 9) * 10 + clampi(nib(p, 6), 9), HR_LIMIT);
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    function automatic logic [31:0] to_bcd(input int t);
        int c, s, m, h;
        c = t % 100;
        s = (t / 100) % 60;
        m = (t / 6000) % 60;
        h = t / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_step();
        m_done = 1'b0;
        m_ovf  = 1'b0;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_t     = 0;
            m_lap   = 0;
            m_lapv  = 1'b0;
            m_down  = 1'b0;
            m_runs  = 0;
        end else if (clear) begin
            m_state = M_IDLE;
            m_t     = 0;
            m_lap   = 0;
            m_lapv  = 1'b0;
            m_runs  = 0;
        end else begin
            if (lap && (m_state == M_RUN || m_state == M_PAUSE)) begin
                m_lap  = m_t;
                m_lapv = 1'b1;
            end
            if (m_state == M_IDLE) m_down = mode;
            if (load && m_state != M_RUN) begin
                m_t     = preset_to_cs(preset);
                m_runs  = 0;
                m_state = M_IDLE;
            end else begin
                case (m_state)
                    M_IDLE: begin
                        if (start && !(m_down && m_t == 0)) begin
                            m_state = M_RUN;
                            m_runs  = 0;
                        end
                    end
                    M_RUN: begin
                        m_runs++;
                        if (stop) m_state = M_PAUSE;
                        if (m_runs == TICK_DIV) begin
                            m_runs = 0;
                            if (!m_down) begin
                                m_t++;
                                if (m_t == DAY_CS) begin
                                    m_t   = 0;
                                    m_ovf = 1'b1;
                                end
                            end else begin
                                m_t--;
                                if (m_t == 0) begin
                                    m_state = M_DONE;
                                    m_done  = 1'b1;
                                end
                            end
                        end
                    end
                    M_PAUSE: begin
                        if (start && !stop) m_state = M_RUN;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("time",      o_time,             to_bcd(m_t));
        check_eq("lap",       o_lap,              to_bcd(m_lap));
        check_eq("lap_valid", 32'(o_lap_valid),   32'(m_lapv));
        check_eq("running",   32'(o_running),     32'(m_state == M_RUN));
        check_eq("done",      32'(o_done),        32'(m_done));
        check_eq("overflow",  32'(o_overflow),    32'(m_ovf));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] p);
        preset = p;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        load   = 1'b0;
        preset = '0;
        lap    = 1'b0;
        cycle();
        cycle();
        check_eq("reset_time", o_time, 32'h0);
        rst_n = 1'b1;
        cycle();

        // Count up from zero: first tick after 4 RUN cycles, 1.00 s after 400.
        do_start();
        check_eq("up_running", 32'(o_running), 32'h1);
        repeat (3) cycle();
        check_eq("up_before_tick", o_time, 32'h0);
        cycle();
        check_eq("up_first_tick", o_time, 32'h1);
        repeat (396) cycle();
        check_eq("up_one_second", o_time, 32'h100);

        // Wrap at HR_LIMIT:59:59.99.
        do_clear();
        do_load(32'h2359_5999);
        do_start();
        repeat (4) cycle();
        check_eq("wrap_time", o_time, 32'h0);
        check_eq("wrap_ovf", 32'(o_overflow), 32'h1);
        check_eq("wrap_running", 32'(o_running), 32'h1);
        cycle();
        check_eq("wrap_ovf_pulse", 32'(o_overflow), 32'h0);

        // Countdown to expiry, then start is ignored in DONE.
        do_clear();
        mode = 1'b1;
        do_load(32'h0000_0002);
        do_start();
        repeat (4) cycle();
        check_eq("down_one", o_time, 32'h1);
        repeat (4) cycle();
        check_eq("down_zero", o_time, 32'h0);
        check_eq("down_done", 32'(o_done), 32'h1);
        check_eq("down_stopped", 32'(o_running), 32'h0);
        do_start();
        check_eq("done_start_ign", 32'(o_running), 32'h0);
        mode = 1'b0;

        // Pause two cycles into a tick period, resume with the held prescaler.
        do_clear();
        do_start();
        repeat (40) cycle();
        check_eq("pause_pre", o_time, 32'h10);
        cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (20) cycle();
        check_eq("pause_frozen", o_time, 32'h10);
        do_start();
        cycle();
        check_eq("resume_wait", o_time, 32'h10);
        cycle();
        check_eq("resume_tick", o_time, 32'h11);

        // Lap coinciding with a tick captures the pre-tick value.
        do_clear();
        do_start();
        repeat (39) cycle();
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        check_eq("lap_value", o_lap, 32'h9);
        check_eq("lap_time", o_time, 32'h10);
        check_eq("lap_flag", 32'(o_lap_valid), 32'h1);
        do_clear();
        check_eq("clear_lap", o_lap, 32'h0);
        check_eq("clear_lapv", 32'(o_lap_valid), 32'h0);

        // Saturating load that wins over a same-cycle start.
        preset = 32'h9977_590F;
        load   = 1'b1;
        start  = 1'b1;
        cycle();
        load   = 1'b0;
        start  = 1'b0;
        check_eq("sat_load", o_time, 32'h2357_5909);
        check_eq("load_beats_start", 32'(o_running), 32'h0);

        // Reset while running.
        do_start();
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("rst_time", o_time, 32'h0);
        check_eq("rst_running", 32'(o_running), 32'h0);

        // Random control traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            clear = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 23) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            lap   = ($urandom_range(0, 7) == 0);
            mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       preset = $urandom();
                1:       preset = 32'h2359_5990 | 32'($urandom_range(0, 15));
                default: preset = 32'($urandom_range(0, 20));
            endcase
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
